fpu_seq: RTL and testbench

Initiator-side sequencer that drives the FPU datapath on behalf of the CPU execute stage.
- Accepts one FP operation per valid/ready handshake.
- Registers and holds the operands and function code stable on the FPU inputs.
- Counts the per-function pipeline latency, captures the result and flags, and returns them on a valid/ready response channel.
- Keeps sticky exception flags for the FP status register.

---
 rtl/fpu_seq.sv | 138 +++++++++++++
 tb/tb_fpu_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_seq.sv
// ============================================================================
// fpu_seq : sequences one FP operation at a time through a fixed-latency FPU
//           and returns the result and flags on a valid/ready channel.
// Rev 1.0
// ============================================================================
`default_nettype none

module fpu_seq #(
  parameter int LAT_CVT    = 6,
  parameter int LAT_ADDSUB = 7,
  parameter int LAT_MUL    = 5,
  parameter int LAT_DIV    = 6,
  parameter int LAT_SQRT   = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_func,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic [3:0]  sticky_flags,
  input  logic        clr_sticky,
  input  logic        flush,
  output logic [31:0] fpu_in1,
  output logic [31:0] fpu_in2,
  output logic [2:0]  fpu_func,
  input  logic [31:0] fpu_out,
  input  logic        fpu_overflow,
  input  logic        fpu_underflow,
  input  logic        fpu_nan,
  input  logic        fpu_divzero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_in1;
  logic [31:0] r_in2;
  logic [2:0]  r_func;
  logic [31:0] r_result;
  logic [3:0]  r_flags;
  logic [3:0]  r_sticky;
  logic        r_rsp_valid;

  logic [3:0]  w_flags;
  logic        w_accept;
  logic        w_capture;

  function automatic logic [4:0] lat_of(input logic [2:0] f);
    case (f)
      3'd0, 3'd1: lat_of = 5'(LAT_CVT);
      3'd2:       lat_of = 5'(LAT_SQRT);
      3'd4, 3'd5: lat_of = 5'(LAT_ADDSUB);
      3'd6:       lat_of = 5'(LAT_MUL);
      3'd7:       lat_of = 5'(LAT_DIV);
      default:    lat_of = 5'd0;
    endcase
  endfunction

  // req_ready is gated by rst_ni so it reads 0 throughout reset
  assign req_ready = rst_ni && (r_state == ST_IDLE) && !flush;
  assign w_accept  = req_valid && req_ready;
  assign w_capture = (r_state == ST_BUSY) && (r_cnt == 5'd0) && !flush;
  assign w_flags   = {fpu_divzero, fpu_nan, fpu_underflow, fpu_overflow};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 5'd0;
      r_in1       <= 32'd0;
      r_in2       <= 32'd0;
      r_func      <= 3'd0;
      r_result    <= 32'd0;
      r_flags     <= 4'd0;
      r_sticky    <= 4'd0;
      r_rsp_valid <= 1'b0;
    end else begin
      // clear takes priority over the old value, then the new capture is ORed in
      if (clr_sticky || w_capture)
        r_sticky <= (clr_sticky ? 4'd0 : r_sticky) | (w_capture ? w_flags : 4'd0);

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_in1   <= req_a;
            r_in2   <= req_b;
            r_func  <= req_func;
            r_cnt   <= lat_of(req_func);
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (flush) begin
            r_state <= ST_IDLE;
          end else if (r_cnt != 5'd0) begin
            r_cnt <= r_cnt - 5'd1;
          end else begin
            r_result    <= fpu_out;
            r_flags     <= w_flags;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (flush || rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign fpu_in1      = r_in1;
  assign fpu_in2      = r_in2;
  assign fpu_func     = r_func;
  assign rsp_result   = r_result;
  assign rsp_flags    = r_flags;
  assign sticky_flags = r_sticky;
  assign rsp_valid    = r_rsp_valid;

endmodule

`default_nettype wire

// File: tb/tb_fpu_seq.sv
// ============================================================================
// tb_fpu_seq : directed table-driven bench for fpu_seq with a delayed FPU model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fpu_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_func = 3'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic [3:0]  sticky_flags;
  logic        clr_sticky = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] fpu_in1;
  logic [31:0] fpu_in2;
  logic [2:0]  fpu_func;
  logic [31:0] fpu_out = 32'hDEADBEEF;
  logic [3:0]  fpu_flg = 4'd0;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  fpu_seq dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .sticky_flags(sticky_flags),
    .clr_sticky(clr_sticky), .flush(flush),
    .fpu_in1(fpu_in1), .fpu_in2(fpu_in2), .fpu_func(fpu_func),
    .fpu_out(fpu_out),
    .fpu_overflow(fpu_flg[0]), .fpu_underflow(fpu_flg[1]),
    .fpu_nan(fpu_flg[2]), .fpu_divzero(fpu_flg[3])
  );

  typedef struct {
    logic [2:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;
    int          lat;
    logic        clr;
    logic [3:0]  sticky;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one op; the FPU model presents the result only after lat edges.
  task automatic do_op(input vec_t v);
    req_valid = 1'b1; req_func = v.func; req_a = v.a; req_b = v.b;
    fpu_out = 32'hDEADBEEF; fpu_flg = 4'd0;
    #1;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    chk("fpu_in1", fpu_in1, v.a);
    chk("fpu_in2", fpu_in2, v.b);
    chk("fpu_func", {29'd0, fpu_func}, {29'd0, v.func});
    for (int k = 0; k < v.lat; k++) begin
      chk("busy_no_valid", {31'd0, rsp_valid}, 32'd0);
      chk("busy_func_held", {29'd0, fpu_func}, {29'd0, v.func});
      chk("busy_not_ready", {31'd0, req_ready}, 32'd0);
      step();
    end
    fpu_out = v.res; fpu_flg = v.flags; clr_sticky = v.clr;
    step();
    clr_sticky = 1'b0; fpu_out = 32'hDEADBEEF; fpu_flg = 4'd0;
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_result", rsp_result, v.res);
    chk("rsp_flags", {28'd0, rsp_flags}, {28'd0, v.flags});
    chk("sticky", {28'd0, sticky_flags}, {28'd0, v.sticky});
    chk("done_func_held", {29'd0, fpu_func}, {29'd0, v.func});
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_dropped", {31'd0, rsp_valid}, 32'd0);
    chk("back_to_idle", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    vec_t v;
    //           func  a             b             res           flags    lat clr sticky
    vecs[0] = '{3'd4, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000, 7, 1'b0, 4'b0000}; // ADD
    vecs[1] = '{3'd3, 32'h00000000, 32'h3F800000, 32'hBF800000, 4'b0000, 0, 1'b0, 4'b0000}; // NEG
    vecs[2] = '{3'd7, 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b1000, 6, 1'b0, 4'b1000}; // DIV/0
    vecs[3] = '{3'd6, 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, 5, 1'b0, 4'b1000}; // MUL
    vecs[4] = '{3'd5, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0000, 7, 1'b0, 4'b1000}; // SUB
    vecs[5] = '{3'd0, 32'h00000000, 32'h00000005, 32'h40A00000, 4'b0000, 6, 1'b0, 4'b1000}; // CVTIS
    vecs[6] = '{3'd1, 32'h00000000, 32'h40A00000, 32'h00000005, 4'b0010, 6, 1'b0, 4'b1010}; // CVTSI
    vecs[7] = '{3'd7, 32'h40000000, 32'h00000000, 32'h7F800000, 4'b1000, 6, 1'b0, 4'b1000}; // after clr
    vecs[8] = '{3'd6, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0001, 5, 1'b1, 4'b0001}; // clr+capture

    #3;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_fpu_in1", fpu_in1, 32'd0);
    chk("rst_fpu_func", {29'd0, fpu_func}, 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_sticky", {28'd0, sticky_flags}, 32'd0);
    step(); step();
    rst_ni = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i]);
      finish_rsp();
    end

    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    chk("clr_sticky", {28'd0, sticky_flags}, 32'd0);

    for (int i = 7; i < 9; i++) begin
      do_op(vecs[i]);
      finish_rsp();
    end

    // Backpressure on a SQRT response
    v = '{3'd2, 32'h00000000, 32'h40000000, 32'h3FB504F3, 4'b0000, 16, 1'b0, 4'b0001};
    do_op(v);
    for (int k = 0; k < 10; k++) begin
      req_valid = (k == 4); req_func = 3'd4; req_a = 32'h12345678;
      #1;
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_result", rsp_result, 32'h3FB504F3);
      chk("bp_flags", {28'd0, rsp_flags}, 32'd0);
      chk("bp_not_ready", {31'd0, req_ready}, 32'd0);
      step();
    end
    req_valid = 1'b0;
    chk("bp_no_accept", fpu_in1, 32'h00000000);
    finish_rsp();
    v = '{3'd4, 32'h40000000, 32'h40000000, 32'h40800000, 4'b0000, 7, 1'b0, 4'b0001};
    do_op(v);
    finish_rsp();

    // Flush three cycles into a DIV whose FPU raises divzero throughout
    req_valid = 1'b1; req_func = 3'd7; req_a = 32'h40400000; req_b = 32'd0;
    fpu_flg = 4'b1000; fpu_out = 32'h7F800000;
    step();
    req_valid = 1'b0;
    step(); step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("flush_no_valid", {31'd0, rsp_valid}, 32'd0);
    chk("flush_idle", {31'd0, req_ready}, 32'd1);
    for (int k = 0; k < 8; k++) step();
    chk("flush_no_late_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("flush_sticky_kept", {28'd0, sticky_flags}, 32'd1);
    fpu_flg = 4'd0;

    // Flush beats a request in IDLE
    flush = 1'b1; req_valid = 1'b1; req_func = 3'd6; req_a = 32'h12345678;
    #1;
    chk("flush_blocks_ready", {31'd0, req_ready}, 32'd0);
    step();
    flush = 1'b0; req_valid = 1'b0;
    #1;
    chk("flush_req_in1", fpu_in1, 32'h40400000);
    chk("flush_req_idle", {31'd0, req_ready}, 32'd1);

    // Asynchronous reset in the middle of an ADD
    req_valid = 1'b1; req_func = 3'd4; req_a = 32'h3F800000; req_b = 32'h3F800000;
    step();
    req_valid = 1'b0;
    step(); step();
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_in1", fpu_in1, 32'd0);
    chk("arst_func", {29'd0, fpu_func}, 32'd0);
    chk("arst_result", rsp_result, 32'd0);
    chk("arst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_sticky", {28'd0, sticky_flags}, 32'd0);
    chk("arst_ready", {31'd0, req_ready}, 32'd0);
    step();
    rst_ni = 1'b1;
    #1;
    chk("arst_release_ready", {31'd0, req_ready}, 32'd1);
    for (int k = 0; k < 8; k++) step();
    chk("arst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    v = '{3'd4, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000, 7, 1'b0, 4'b0000};
    do_op(v);
    finish_rsp();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
